// File: rtl/instruction_fetch_if.sv
// Instruction-memory and issue handshake bundle for instruction_fetch.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 10
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              instr_ready;
    logic              load_PC;
    logic [ADDR_W-1:0] pc_value;

    modport master (
        output imem_addr, imem_req, instruction, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, load_PC, pc_value
    );

    modport slave (
        input  imem_addr, imem_req, instruction, instr_valid,
        output imem_ack, imem_rdata, instr_ready, load_PC, pc_value
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch/issue sequencer: fetches one word at pc, holds it until consumed, then advances or jumps.
// Optional HALT opcode support is enabled by defining IFETCH_HALT_EN.
module instruction_fetch #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted
);
    localparam int unsigned OP_W = 4;
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
`ifdef IFETCH_HALT_EN
    localparam logic [1:0]      HALT    = 2'd2;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;
`endif

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;

    // Next-state, next-pc and instruction capture
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        instr_d = instr_q;
        case (state_q)
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    state_d = FETCH;
                    if (bus.load_PC) pc_d = bus.pc_value;
                    else             pc_d = pc + ADDR_W'(1);
`ifdef IFETCH_HALT_EN
                    // A consumed HALT freezes pc and ignores any jump request
                    if (instr_q[DATA_W-1 -: OP_W] == OP_HALT) begin
                        state_d = HALT;
                        pc_d    = pc;
                    end
`endif
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        valid_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc      <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

`ifdef IFETCH_HALT_EN
    logic halted_q;

    always_ff @(posedge clk) begin
        if (reset) halted_q <= 1'b0;
        else       halted_q <= (state_d == HALT);
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    // Request drops combinationally while reset is held
    assign bus.imem_req    = (state_q == FETCH) && !reset;
    assign bus.imem_addr   = pc;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized bench for instruction_fetch against a transaction-level model.
module tb_instruction_fetch;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc;
    logic       halted;

    instruction_fetch_if #(.ADDR_W(8), .DATA_W(10)) bus();

    instruction_fetch #(.ADDR_W(8), .DATA_W(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
    );

    always #5 clk = ~clk;

`ifdef IFETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: address of current word, whether a word is waiting to be consumed, its value, halt flag
    int         m_pc;
    bit         m_have;
    bit         m_halted;
    logic [9:0] m_word;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs after the falling edge, check, then advance the model.
    task automatic cyc(input bit rst, input bit ack, input logic [9:0] rd,
                       input bit rdy, input bit ld, input logic [7:0] tgt);
        reset           = rst;
        bus.imem_ack    = ack;
        bus.imem_rdata  = rd;
        bus.instr_ready = rdy;
        bus.load_PC     = ld;
        bus.pc_value    = tgt;
        #1;
        if (chk_en) begin
            chk("imem_req",    16'(bus.imem_req),    16'(!rst && !m_have && !m_halted));
            chk("imem_addr",   16'(bus.imem_addr),   16'(m_pc));
            chk("pc",          16'(pc),              16'(m_pc));
            chk("instr_valid", 16'(bus.instr_valid), 16'(m_have));
            chk("instruction", 16'(bus.instruction), 16'(m_word));
            chk("halted",      16'(halted),          16'(m_halted));
        end
        if (rst) begin
            m_pc = 0; m_have = 1'b0; m_word = 10'h000; m_halted = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (!m_have) begin
            if (ack) begin
                m_word = rd;
                m_have = 1'b1;
            end
        end else if (rdy) begin
            m_have = 1'b0;
            if (HALT_EN && m_word[9:6] == 4'hF) m_halted = 1'b1;
            else if (ld)                        m_pc = int'(tgt);
            else                                m_pc = (m_pc + 1) % 256;
        end
        @(negedge clk);
    endtask

    // Immediate ack, then consume with the given jump request.
    task automatic fetch_consume(input logic [9:0] w, input bit ld, input logic [7:0] tgt);
        cyc(1'b0, 1'b1, w, 1'($urandom), 1'($urandom), 8'($urandom));
        cyc(1'b0, 1'($urandom), 10'($urandom), 1'b1, ld, tgt);
    endtask

    initial begin
        @(negedge clk);
        cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;
        // Ack during reset is ignored
        cyc(1'b1, 1'b1, 10'h2AA, 1'b1, 1'b1, 8'h77);

        // Sequential fetch of 1,2,3 with ack in the first FETCH cycle
        fetch_consume(10'h001, 1'b0, 8'h00);
        fetch_consume(10'h002, 1'b0, 8'h00);
        fetch_consume(10'h003, 1'b0, 8'h00);
        chk("pc_after_seq", 16'(pc), 16'd3);

        // Wait states (ack after 3 cycles) and 2 cycles of backpressure with a jump request
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 10'($urandom), 1'($urandom), 1'b1, 8'($urandom));
        cyc(1'b0, 1'b1, 10'h155, 1'b0, 1'b1, 8'h99);
        for (int i = 0; i < 2; i++)
            cyc(1'b0, 1'($urandom), 10'($urandom), 1'b0, 1'b1, 8'($urandom));
        cyc(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 8'h00);
        chk("pc_after_wait", 16'(pc), 16'd4);

        // Jump at pc=5 to 0x2A
        fetch_consume(10'h010, 1'b0, 8'h00);
        fetch_consume(10'h011, 1'b1, 8'h2A);
        cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
        chk("jump_addr", 16'(bus.imem_addr), 16'h2A);

        // Wrap-around: jump to 0xFF then step
        fetch_consume(10'h012, 1'b1, 8'hFF);
        fetch_consume(10'h013, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
        chk("wrap_addr", 16'(bus.imem_addr), 16'h00);

        // Reset while holding 0x3C5 in ISSUE
        cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 10'h3C5, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 10'h1FF, 1'b1, 1'b1, 8'h33);
        cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
        chk("rst_instr", 16'(bus.instruction), 16'h000);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, 10'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom));

        // Halt opcode consumed at pc=7 with a jump request
        cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 7; k++)
            fetch_consume(10'(10'h040 + k), 1'b0, 8'h00);
        fetch_consume(10'b1111000000, 1'b1, 8'h55);
        for (int i = 0; i < 12; i++)
            cyc(1'b0, 1'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        if (HALT_EN) begin
            chk("halt_pc",  16'(pc),     16'd7);
            chk("halt_flag", 16'(halted), 16'd1);
        end else begin
            chk("halt_flag", 16'(halted), 16'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 imem_addr  output  8  instruction memory address; equals pc.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  10  fetched instruction word (iiiidddddd).
REQ-008 instruction  output  10  registered instruction presented to the control unit.
REQ-009 instr_valid  output  1  instruction holds an unconsumed word.
REQ-010 instr_ready  input  1  downstream accepts the instruction this cycle.
REQ-011 load_PC  input  1  jump request from the control unit, decoded from the current instruction.
REQ-012 pc_value  input  8  jump target.
REQ-013 pc  output  8  address of the instruction currently fetched or issued.
REQ-014 halted  output  1  fetch stopped by a HALT opcode.

Function
REQ-015 The FSM SHALL have the states FETCH, ISSUE and HALT, encoded in 2 bits.
REQ-016 FETCH behaviour:
- imem_req=1 and imem_addr=pc, both held stable until imem_ack=1.
- On imem_ack=1: instruction<=imem_rdata, then go to ISSUE next cycle.
REQ-017 ISSUE behaviour:
- instr_valid=1 and imem_req=0.
- instruction is held stable until instr_ready=1.
REQ-018 When in ISSUE with instr_ready=1 and load_PC=1, the block SHALL set pc<=pc_value and go to FETCH.
REQ-019 When in ISSUE with instr_ready=1 and load_PC=0, the block SHALL set pc<=pc+1 modulo 256 (255 wraps to 0) and go to FETCH.
REQ-020 load_PC and pc_value SHALL be ignored outside an ISSUE cycle with instr_ready=1.
REQ-021 imem_ack SHALL be ignored outside FETCH.
REQ-022 instr_valid SHALL be 0 in FETCH and HALT.
REQ-023 Minimum throughput: one instruction per 2 cycles when imem_ack arrives in the first FETCH cycle and instr_ready is held 1.
REQ-024 Fetch latency SHALL be measured from the FETCH entry edge to instr_valid=1: 1 cycle plus the imem_ack wait cycles.
REQ-025 pc SHALL change only on the ISSUE-consume edge or on reset.

Reset
REQ-026 While reset=1 at a rising edge, the block SHALL set:
- state=FETCH, pc=0, instruction=10'b0, instr_valid=0, halted=0;
- imem_req is combinationally 0 while reset=1.
REQ-027 Reset SHALL take priority over every other event.
REQ-028 Reset mid-fetch or mid-issue SHALL discard the pending word and restart at pc=0.
REQ-029 imem_ack asserted in a cycle where reset=1 SHALL be ignored.
REQ-030 In the first cycle after reset deasserts, the block SHALL drive imem_req=1 and imem_addr=0.

Configuration
REQ-031 The halt feature SHALL be controlled by the macro IFETCH_HALT_EN.
REQ-032 With IFETCH_HALT_EN defined:
- A consumed instruction with opcode bits[9:6]=4'b1111 SHALL move the FSM to HALT with pc unchanged.
- HALT SHALL drive halted=1, imem_req=0 and instr_valid=0.
- The block SHALL stay in HALT until reset.
- load_PC SHALL be ignored on the halting consume.
REQ-033 Without IFETCH_HALT_EN:
- The HALT state is absent.
- halted SHALL be tied to 0.
- Opcode 4'b1111 SHALL be treated like any other instruction (pc+1).

Verification
REQ-034 Sequential fetch: reset, then imem_ack in the first FETCH cycle with words 10'h001,10'h002,10'h003 and instr_ready=1 -> imem_addr 0,1,2; instr_valid one cycle in every 2; pc ends at 3.
REQ-035 Wait states and backpressure: imem_ack delayed 3 cycles and instr_ready low for 2 ISSUE cycles -> imem_req and imem_addr stable throughout the wait; instruction and instr_valid stable throughout the backpressure; pc unchanged until consume.
REQ-036 Jump: consume at pc=5 with load_PC=1 and pc_value=8'h2A -> next imem_addr=8'h2A; load_PC=1 with instr_ready=0 -> pc unchanged.
REQ-037 Wrap-around: pc=255 consumed with load_PC=0 -> next imem_addr=0.
REQ-038 Reset mid-operation: reset asserted in ISSUE holding 10'h3C5 -> next cycle instr_valid=0 and instruction=0; cycle after reset deasserts: imem_req=1, imem_addr=0.
REQ-039 Halt, with IFETCH_HALT_EN: consume 10'b1111000000 at pc=7 -> halted=1, imem_req=0, pc=7 for 10 or more cycles; without the macro -> next imem_addr=8.
